// File: rtl/softmax_normalize_if.sv
// softmax_normalize_if: valid/ready stream bundle for the softmax normalisation stage
// in_valid/in_ready/a : exp-value input stream (a is unsigned fixed-point)
// out_valid/out_ready/c/out_last : normalised output stream, out_last marks the vector end
interface softmax_normalize_if #(parameter int BITS = 32) ();
    logic            in_valid;
    logic            in_ready;
    logic [BITS-1:0] a;
    logic            out_valid;
    logic            out_ready;
    logic [BITS-1:0] c;
    logic            out_last;
    modport master (output in_valid, a, out_ready, input in_ready, out_valid, c, out_last);
    modport slave (input in_valid, a, out_ready, output in_ready, out_valid, c, out_last);
endinterface

// File: rtl/softmax_normalize.sv
// softmax_normalize: buffers VEC_LEN exp values, divides 2^(2*FRAC_BITS) by their sum, streams each value scaled by 1/sum
// clk, rst : clock and synchronous active-high reset
// bus      : slave side of softmax_normalize_if (input stream a, output stream c/out_last)
// busy     : high unless idle in FILL with no words buffered
module softmax_normalize #(
    parameter int BITS      = 32,
    parameter int FRAC_BITS = 16,
    parameter int VEC_LEN   = 8,
    parameter int ACC_BITS  = BITS + $clog2(VEC_LEN)
) (
    input  logic                clk,
    input  logic                rst,
    softmax_normalize_if.slave  bus,
    output logic                busy
);
    localparam int IW = $clog2(VEC_LEN);
    localparam int NW = BITS + 1;
    localparam int CW = $clog2(BITS + 2);
    typedef enum logic [1:0] {FILL, RECIP, SAT, EMIT} state_t;
    state_t              state;
    logic [BITS-1:0]     mem [VEC_LEN];
    logic [IW-1:0]       count, index;
    logic [ACC_BITS-1:0] sum, sum_next, div, rem;
    logic [ACC_BITS:0]   trial;
    logic [NW-1:0]       num;
    logic [CW-1:0]       it;
    logic [BITS-1:0]     recip, sat_val;
    logic [2*BITS-1:0]   prod, scaled;
    logic                take, load, ge;
    always_comb begin
        take     = bus.in_valid && bus.in_ready;
        sum_next = sum + ACC_BITS'(bus.a);
        // num shifts numerator bits out of the top and quotient bits in at the bottom
        trial    = {rem, num[NW-1]};
        ge       = trial >= {1'b0, div};
        prod     = {{BITS{1'b0}}, mem[index]} * {{BITS{1'b0}}, recip};
        scaled   = prod >> FRAC_BITS;
        sat_val  = |scaled[2*BITS-1:BITS] ? '1 : scaled[BITS-1:0];
        // a loaded out_last blocks further loads until it is accepted
        load     = state == EMIT && !(bus.out_valid && !bus.out_ready) && !bus.out_last;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= FILL;
            count         <= '0;
            index         <= '0;
            sum           <= '0;
            div           <= '0;
            rem           <= '0;
            num           <= '0;
            it            <= '0;
            recip         <= '0;
            busy          <= 1'b0;
            bus.in_ready  <= 1'b1;
            bus.out_valid <= 1'b0;
            bus.out_last  <= 1'b0;
            bus.c         <= '0;
        end else begin
            if (take) begin
                mem[count] <= bus.a;
                sum        <= sum_next;
                count      <= count + IW'(1);
                busy       <= 1'b1;
                if (count == IW'(VEC_LEN - 1)) begin
                    state        <= RECIP;
                    bus.in_ready <= 1'b0;
                    div          <= sum_next;
                    rem          <= '0;
                    num          <= NW'(1) << (2 * FRAC_BITS);
                    it           <= '0;
                end
            end
            if (state == RECIP) begin
                rem <= ge ? ACC_BITS'(trial - {1'b0, div}) : trial[ACC_BITS-1:0];
                num <= {num[NW-2:0], ge};
                it  <= it + CW'(1);
                if (it == CW'(BITS)) state <= SAT;
            end
            // a zero divisor yields an all-ones quotient, which saturates here too
            if (state == SAT) begin
                recip <= num[NW-1] ? '1 : num[BITS-1:0];
                index <= '0;
                state <= EMIT;
            end
            if (bus.out_valid && bus.out_ready) begin
                bus.out_valid <= 1'b0;
                if (bus.out_last) begin
                    bus.out_last <= 1'b0;
                    state        <= FILL;
                    count        <= '0;
                    sum          <= '0;
                    busy         <= 1'b0;
                    bus.in_ready <= 1'b1;
                end
            end
            if (load) begin
                bus.c         <= sat_val;
                bus.out_valid <= 1'b1;
                bus.out_last  <= index == IW'(VEC_LEN - 1);
                index         <= index + IW'(1);
            end
        end
    end
endmodule

// File: doc/softmax_normalize.md
Name: softmax_normalize

Overview:
- Fixed-point softmax normalisation stage. Sits directly downstream of the exponent-approximation stage and consumes its exp(x) output stream.
- Buffers VEC_LEN exponent values and accumulates their sum.
- Computes 1/sum with a sequential restoring divider.
- Streams each buffered value multiplied by 1/sum, with valid/ready handshakes on both sides.

Parameters:
- BITS, 32, data width of input and output words.
- FRAC_BITS, 16, fractional bits of the unsigned fixed-point format (FIXED_16_16 with the defaults).
- VEC_LEN, 8, elements per softmax vector; must be 2 or more.
- ACC_BITS, BITS+$clog2(VEC_LEN), width of the sum accumulator; derived, do not override.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  input word valid.
- in_ready  out  1  stage can accept an input word.
- a  in  BITS  exp value, unsigned fixed-point.
- out_valid  out  1  normalised word valid.
- out_ready  in  1  downstream accepts the word.
- c  out  BITS  normalised value, unsigned fixed-point.
- out_last  out  1  marks the final element of the vector.
- busy  out  1  high in any state other than FILL with count 0.

Behaviour:
- Reset: in_ready=1, out_valid=0, out_last=0, c=0, busy=0. State goes to FILL, and the count, sum and reciprocal registers clear. A reset asserted in any state aborts the vector in progress; partial data is discarded.
- FILL:
  - in_ready=1. A transfer occurs when in_valid and in_ready are both high.
  - Each transfer writes a into buf[count], adds it to sum (ACC_BITS wide, zero-extended, cannot overflow), and increments count.
  - The transfer at count==VEC_LEN-1 moves the state to RECIP; the divider is initialised with numerator 2^(2*FRAC_BITS) and divisor sum+a.
- RECIP:
  - in_ready=0. Restoring division produces one quotient bit per cycle, for exactly BITS+1 cycles.
  - The quotient is floor(2^(2*FRAC_BITS)/sum). If it exceeds 2^BITS-1, recip saturates to 2^BITS-1.
  - If sum==0, recip=2^BITS-1 and the divider does not hang.
  - After the last iteration the state moves to EMIT with index=0.
- EMIT:
  - in_ready=0.
  - Output register: c = sat((buf[index]*recip) >> FRAC_BITS). The product is 2*BITS wide, truncated, not rounded. The result saturates to 2^BITS-1.
  - The output register loads when it is empty, or when out_valid and out_ready are both high. out_last=1 when index==VEC_LEN-1.
  - c, out_valid and out_last hold stable while out_valid=1 and out_ready=0.
  - When the element with out_last is accepted: out_valid drops on the next edge unless reloaded, the state returns to FILL, and the count and sum clear.
- Latency:
  - The last-input accepting edge is edge 0. out_valid first rises after edge BITS+3 and is high in the following cycle.
  - With out_ready held high, one element is emitted per cycle.
  - Total vector turnaround is VEC_LEN + BITS + 3 + VEC_LEN cycles.
- No overlap between vectors: in_ready stays 0 from the last-input edge until the cycle after the final output is accepted. in_valid during that window is ignored and no data is lost in the DUT.
- busy is registered and follows the state as defined under Ports.

Test Plan:
All scenarios use VEC_LEN=4, BITS=32, FRAC_BITS=16.
- Uniform input: four words of 0x00010000 (1.0) -> sum 0x40000, recip 0x4000. Outputs are 0x4000 x4, with out_last only on the 4th. First out_valid appears BITS+3 edges after the last input.
- Mixed input: 0x10000, 0x10000, 0x20000, 0x40000 -> sum 8.0, recip 0x2000. Outputs are 0x2000, 0x2000, 0x4000, 0x8000; their sum is exactly 0x10000.
- Zero and saturation:
  - All-zero vector -> recip 0xFFFFFFFF, outputs 0x0 x4, FSM returns to FILL.
  - Vector 0x1, 0, 0, 0 -> sum=1, recip saturated 0xFFFFFFFF. Outputs are 0xFFFF, 0, 0, 0.
- Backpressure: uniform vector with out_ready toggling 1,0,0,1,0,1... -> c and out_last stay stable while stalled. Exactly four transfers occur, with no duplicates or drops. in_ready stays 0 until the final transfer completes, then rises.
- Reset mid-operation: assert rst for one cycle during RECIP, and separately after 2 outputs in EMIT. Next cycle: out_valid=0, in_ready=1, busy=0. A following uniform vector produces 0x4000 x4, unaffected by the aborted data.
- Input stall: gaps of 0-3 cycles in in_valid across a vector -> results identical to the gap-free case. in_valid held high after the 4th word is not accepted until the FSM is back in FILL.
